cmsdk_uart_send: RTL and testbench

- Testbench-side 8N1 serial transmitter that drives a UART receive pin, for example the DUT RXD or the capture model's RXD.
- Bytes enter through a valid/ready port into an internal FIFO and are serialised LSB-first at CLK/BAUD_DIV.
- Tests use it to inject console input, and to send the ESC control sequences and the 0x04 end-of-test code to the capture side.

---
 rtl/cmsdk_uart_send_pkg.sv | 26 ++
 rtl/cmsdk_uart_send_if.sv | 40 ++++
 rtl/cmsdk_uart_send_fifo.sv | 61 ++++++
 rtl/cmsdk_uart_send.sv | 203 ++++++++++++++++++++
 tb/tb_cmsdk_uart_send.sv | 285 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cmsdk_uart_send_pkg.sv
// cmsdk_uart_send_pkg: shared types and constants for the UART send model.
// It holds the FSM state encoding, the console protocol characters and a
// width helper for the FIFO occupancy count.
package cmsdk_uart_send_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam logic [7:0] CHAR_ESC     = 8'h1B;
  localparam logic [7:0] CHAR_AUXCTRL = 8'h10;
  localparam logic [7:0] CHAR_DBG_ON  = 8'h11;
  localparam logic [7:0] CHAR_DBG_OFF = 8'h12;
  localparam logic [7:0] CHAR_EOT     = 8'h04;
  localparam logic [7:0] CHAR_CR      = 8'h0D;
  localparam logic [7:0] CHAR_LF      = 8'h0A;

  // Occupancy needs one extra bit so that "full" (== depth) is representable.
  function automatic int level_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/cmsdk_uart_send_if.sv
// cmsdk_uart_send_if: byte-submission and status bundle of the UART sender.
// With CMSDK_UART_SEND_AUX_EN defined it also carries the AUX request port.
interface cmsdk_uart_send_if
  import cmsdk_uart_send_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
);
  logic                                ENABLE;
  logic                                TX_VALID;
  logic [7:0]                          TX_DATA;
  logic                                TX_READY;
  logic                                TXD;
  logic                                BUSY;
  logic [level_width(FIFO_DEPTH)-1:0]  FIFO_LEVEL;
  logic [15:0]                         TX_COUNT;
`ifdef CMSDK_UART_SEND_AUX_EN
  logic                                AUX_REQ;
  logic [7:0]                          AUX_DATA;
  logic                                AUX_ACK;
`endif

  modport master (
    output ENABLE, TX_VALID, TX_DATA,
`ifdef CMSDK_UART_SEND_AUX_EN
    output AUX_REQ, AUX_DATA,
    input  AUX_ACK,
`endif
    input  TX_READY, TXD, BUSY, FIFO_LEVEL, TX_COUNT
  );

  modport slave (
    input  ENABLE, TX_VALID, TX_DATA,
`ifdef CMSDK_UART_SEND_AUX_EN
    input  AUX_REQ, AUX_DATA,
    output AUX_ACK,
`endif
    output TX_READY, TXD, BUSY, FIFO_LEVEL, TX_COUNT
  );

endinterface

// File: rtl/cmsdk_uart_send_fifo.sv
// cmsdk_uart_send_fifo: byte FIFO feeding the serialiser. The head word is
// read combinationally so the pop edge can load it straight into the shift
// register; pointers wrap naturally because FIFO_DEPTH is a power of two.
module cmsdk_uart_send_fifo
  import cmsdk_uart_send_pkg::*;
#(
  parameter int FIFO_DEPTH = 16
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               push,
  input  logic                               pop,
  input  logic [7:0]                         wr_data,
  output logic [7:0]                         rd_data,
  output logic                               full,
  output logic                               empty,
  output logic [level_width(FIFO_DEPTH)-1:0] level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = level_width(FIFO_DEPTH);

  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          w_push_ok;
  logic          w_pop_ok;

  // Full blocks a push even when a pop happens in the same cycle.
  assign full      = (r_level == LW'(FIFO_DEPTH));
  assign empty     = (r_level == '0);
  assign w_push_ok = push && !full;
  assign w_pop_ok  = pop && !empty;
  assign rd_data   = r_mem[r_rd_ptr];
  assign level     = r_level;

  // Storage write; no reset so the array can map onto RAM.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Pointer and occupancy update; simultaneous push and pop cancel out.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_level <= r_level + LW'(1);
        2'b01:   r_level <= r_level - LW'(1);
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/cmsdk_uart_send.sv
// cmsdk_uart_send: 8N1 serial transmitter that drives a UART receive pin.
// Bytes are queued in a FIFO and shifted out LSB-first at CLK/BAUD_DIV.
// Optional feature macro: CMSDK_UART_SEND_AUX_EN adds an AUX request port
// that sends the atomic sequence ESC, AUXCTRL, AUX_DATA ahead of FIFO bytes.
module cmsdk_uart_send
  import cmsdk_uart_send_pkg::*;
#(
  parameter int BAUD_DIV   = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int STOP_BITS  = 1
) (
  input  logic             CLK,
  input  logic             RESET,
  cmsdk_uart_send_if.slave bus
);
  localparam int BW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
  localparam int LW = level_width(FIFO_DEPTH);

  tx_state_t     r_state;
  tx_state_t     w_state_next;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_next;
  logic [2:0]    r_bit;
  logic [2:0]    w_bit_next;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_next;
  logic          r_txd;
  logic          w_txd_next;
  logic [15:0]   r_tx_count;
  logic          w_baud_end;
  logic          w_frame_done;
  logic          w_boundary;
  logic          w_load;
  logic          w_pop;
  logic [7:0]    w_load_byte;
  logic [7:0]    w_head;
  logic          w_full;
  logic          w_empty;
  logic [LW-1:0] w_level;

  cmsdk_uart_send_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst     (RESET),
    .push    (bus.TX_VALID),
    .pop     (w_pop),
    .wr_data (bus.TX_DATA),
    .rd_data (w_head),
    .full    (w_full),
    .empty   (w_empty),
    .level   (w_level)
  );

  assign w_baud_end   = (r_baud == BW'(BAUD_DIV - 1));
  assign w_frame_done = (r_state == STOP) && w_baud_end && (r_bit == 3'(STOP_BITS - 1));
  // A new frame may be committed while idle or on the last cycle of a stop bit.
  assign w_boundary   = (r_state == IDLE) || w_frame_done;

`ifdef CMSDK_UART_SEND_AUX_EN
  logic [1:0] r_aux_left;
  logic [7:0] r_aux_data;
  logic       r_aux_ack;
  logic       w_aux_cont;
  logic       w_aux_start;

  // An ESC sequence in flight ignores ENABLE so it always completes whole.
  assign w_aux_cont  = w_boundary && (r_aux_left != 2'd0);
  assign w_aux_start = w_boundary && !w_aux_cont && bus.ENABLE && bus.AUX_REQ;
  assign w_pop       = w_boundary && !w_aux_cont && !w_aux_start && bus.ENABLE && !w_empty;
  assign w_load      = w_aux_cont || w_aux_start || w_pop;

  // Pick the byte for the next frame: ESC sequence first, then FIFO head.
  always_comb begin
    w_load_byte = w_head;
    if (w_aux_start) begin
      w_load_byte = CHAR_ESC;
    end else if (w_aux_cont) begin
      w_load_byte = (r_aux_left == 2'd2) ? CHAR_AUXCTRL : r_aux_data;
    end
  end

  // Count the frames still owed to the ESC sequence and pulse the ack.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_aux_left <= '0;
      r_aux_data <= '0;
      r_aux_ack  <= 1'b0;
    end else begin
      r_aux_ack <= w_aux_start;
      if (w_aux_start) begin
        r_aux_left <= 2'd2;
        r_aux_data <= bus.AUX_DATA;
      end else if (w_aux_cont) begin
        r_aux_left <= r_aux_left - 2'd1;
      end
    end
  end

  assign bus.AUX_ACK = r_aux_ack;
`else
  assign w_pop       = w_boundary && bus.ENABLE && !w_empty;
  assign w_load      = w_pop;
  assign w_load_byte = w_head;
`endif

  // Next-state, counters and next TXD level (registered so TXD is glitch-free).
  always_comb begin
    w_state_next = r_state;
    w_baud_next  = r_baud;
    w_bit_next   = r_bit;
    w_shift_next = r_shift;
    w_txd_next   = 1'b1;
    if (w_load) begin
      w_state_next = START;
      w_baud_next  = '0;
      w_bit_next   = '0;
      w_shift_next = w_load_byte;
    end else begin
      case (r_state)
        IDLE: begin
          w_baud_next = '0;
        end
        START: begin
          if (w_baud_end) begin
            w_state_next = DATA;
            w_baud_next  = '0;
            w_bit_next   = '0;
          end else begin
            w_baud_next = r_baud + BW'(1);
          end
        end
        DATA: begin
          if (w_baud_end) begin
            w_baud_next = '0;
            if (r_bit == 3'd7) begin
              w_state_next = STOP;
              w_bit_next   = '0;
            end else begin
              w_bit_next = r_bit + 3'd1;
            end
          end else begin
            w_baud_next = r_baud + BW'(1);
          end
        end
        STOP: begin
          if (w_baud_end) begin
            w_baud_next = '0;
            if (r_bit == 3'(STOP_BITS - 1)) begin
              w_state_next = IDLE;
              w_bit_next   = '0;
            end else begin
              w_bit_next = r_bit + 3'd1;
            end
          end else begin
            w_baud_next = r_baud + BW'(1);
          end
        end
        default: begin
          w_state_next = IDLE;
          w_baud_next  = '0;
        end
      endcase
    end
    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = w_shift_next[w_bit_next];
      default: w_txd_next = 1'b1;
    endcase
  end

  // State, counters, shift register and line register; reset abandons a frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state    <= IDLE;
      r_baud     <= '0;
      r_bit      <= '0;
      r_shift    <= '0;
      r_txd      <= 1'b1;
      r_tx_count <= '0;
    end else begin
      r_state <= w_state_next;
      r_baud  <= w_baud_next;
      r_bit   <= w_bit_next;
      r_shift <= w_shift_next;
      r_txd   <= w_txd_next;
      if (w_frame_done) begin
        r_tx_count <= r_tx_count + 16'd1;
      end
    end
  end

  assign bus.TXD        = r_txd;
  assign bus.TX_READY   = !w_full && !RESET;
  assign bus.BUSY       = (r_state != IDLE) || (w_level != '0);
  assign bus.FIFO_LEVEL = w_level;
  assign bus.TX_COUNT   = r_tx_count;

  // Offering a byte with unknown bits is a protocol error by the requester.
  a_tx_data_known: assert property (@(posedge CLK) disable iff (RESET)
    bus.TX_VALID |-> !$isunknown(bus.TX_DATA));

endmodule

// File: tb/tb_cmsdk_uart_send.sv
// tb_cmsdk_uart_send: directed bench for cmsdk_uart_send. Instance A runs at
// BAUD_DIV=1 and is looped back into a small capture model; instance B runs
// at BAUD_DIV=4 for the bit-width check. CMSDK_UART_SEND_AUX_EN adds the AUX case.
`timescale 1ns/1ps
module tb_cmsdk_uart_send;
  import cmsdk_uart_send_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  cmsdk_uart_send_if #(.FIFO_DEPTH(16)) if_a ();
  cmsdk_uart_send_if #(.FIFO_DEPTH(16)) if_b ();

  cmsdk_uart_send #(.BAUD_DIV(1), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut_a (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if_a)
  );

  cmsdk_uart_send #(.BAUD_DIV(4), .FIFO_DEPTH(16), .STOP_BITS(1)) u_dut_b (
    .CLK   (clk),
    .RESET (rst),
    .bus   (if_b)
  );

  // Capture model on instance A's TXD, sampled mid-bit on the falling edge.
  logic [7:0] rx_q [$];
  logic       m_busy = 1'b0;
  int         m_cnt = 0;
  logic [7:0] m_sh = '0;
  int         m_stop_err = 0;
  logic       m_eot = 1'b0;
  int         m_esc = 0;
  logic [7:0] m_aux = '0;

  always @(negedge clk) begin
    if (rst) begin
      m_busy <= 1'b0;
      m_cnt  <= 0;
      m_eot  <= 1'b0;
      m_esc  <= 0;
    end else if (!m_busy) begin
      if (if_a.TXD == 1'b0) begin
        m_busy <= 1'b1;
        m_cnt  <= 0;
      end
    end else if (m_cnt < 8) begin
      m_sh  <= {if_a.TXD, m_sh[7:1]};
      m_cnt <= m_cnt + 1;
    end else begin
      m_busy <= 1'b0;
      if (if_a.TXD !== 1'b1) m_stop_err <= m_stop_err + 1;
      rx_q.push_back(m_sh);
      $display("rx byte 0x%02h at %0t", m_sh, $time);
      if (m_esc == 2) begin
        m_aux <= m_sh;
        m_esc <= 0;
      end else if (m_esc == 1) begin
        m_esc <= (m_sh == CHAR_AUXCTRL) ? 2 : 0;
      end else if (m_sh == CHAR_ESC) begin
        m_esc <= 1;
      end else if (m_sh == CHAR_EOT) begin
        m_eot <= 1'b1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_rx(input string tag, input int n, input int budget);
    int t;
    t = 0;
    while (rx_q.size() < n && t < budget) begin
      tick();
      t++;
    end
    check_val(tag, rx_q.size(), n);
  endtask

  logic [9:0]  frame1;
  logic [19:0] frame2;
  int          k;
  int          zeros;
  logic        rdy_before;

  initial begin
    if_a.ENABLE = 1'b1; if_a.TX_VALID = 1'b0; if_a.TX_DATA = '0;
    if_b.ENABLE = 1'b1; if_b.TX_VALID = 1'b0; if_b.TX_DATA = '0;
`ifdef CMSDK_UART_SEND_AUX_EN
    if_a.AUX_REQ = 1'b0; if_a.AUX_DATA = '0;
    if_b.AUX_REQ = 1'b0; if_b.AUX_DATA = '0;
`endif

    // Reset state
    repeat (3) tick();
    check_val("rst_txd",   if_a.TXD, 1);
    check_val("rst_ready", if_a.TX_READY, 0);
    check_val("rst_busy",  if_a.BUSY, 0);
    check_val("rst_level", if_a.FIFO_LEVEL, 0);
    check_val("rst_count", if_a.TX_COUNT, 0);
    rst = 1'b0;
    #1;
    check_val("rel_ready", if_a.TX_READY, 1);
    tick();

    // 0x41 at BAUD_DIV=1: start bit from the edge after the push
    frame1 = {1'b1, 8'h41, 1'b0};
    if_a.TX_DATA = 8'h41; if_a.TX_VALID = 1'b1;
    tick();
    if_a.TX_VALID = 1'b0;
    check_val("t1_txd_pre", if_a.TXD, 1);
    check_val("t1_level",   if_a.FIFO_LEVEL, 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check_val($sformatf("t1_bit%0d", i), if_a.TXD, frame1[i]);
    end
    check_val("t1_busy_stop", if_a.BUSY, 1);
    tick();
    check_val("t1_busy_end", if_a.BUSY, 0);
    check_val("t1_count",    if_a.TX_COUNT, 1);
    check_val("t1_rx_n",     rx_q.size(), 1);
    if (rx_q.size() > 0) check_val("t1_rx0", rx_q[0], 8'h41);
    rx_q.delete();

    // 0x55 then 0xAA at BAUD_DIV=4, back-to-back, 80 cycles total
    frame2 = {1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    if_b.TX_DATA = 8'h55; if_b.TX_VALID = 1'b1;
    tick();
    if_b.TX_DATA = 8'hAA;
    tick();
    if_b.TX_VALID = 1'b0;
    check_val("t2_level", if_b.FIFO_LEVEL, 1);
    for (int c = 0; c < 80; c++) begin
      if (c == 40) check_val("t2_count_mid", if_b.TX_COUNT, 1);
      check_val($sformatf("t2_cyc%0d", c), if_b.TXD, frame2[c/4]);
      tick();
    end
    check_val("t2_count", if_b.TX_COUNT, 2);
    check_val("t2_busy",  if_b.BUSY, 0);

    // FIFO fill with ENABLE low: 16 of 17 accepted
    if_a.ENABLE = 1'b0; if_a.TX_VALID = 1'b1; k = 0;
    for (int c = 0; c < 20; c++) begin
      if_a.TX_DATA = 8'h60 + 8'(k);
      rdy_before = if_a.TX_READY;
      tick();
      if (rdy_before) k++;
    end
    check_val("t3_accepted", k, 16);
    check_val("t3_level",    if_a.FIFO_LEVEL, 16);
    check_val("t3_ready",    if_a.TX_READY, 0);
    check_val("t3_txd_idle", if_a.TXD, 1);
    if_a.ENABLE = 1'b1;
    tick();
    check_val("t3_level_pop", if_a.FIFO_LEVEL, 15);
    check_val("t3_ready_pop", if_a.TX_READY, 1);
    tick();
    if_a.TX_VALID = 1'b0;
    check_val("t3_level_17", if_a.FIFO_LEVEL, 16);
    wait_rx("t3_rx_n", 17, 260);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      check_val($sformatf("t3_rx%0d", i), rx_q[i], 8'h60 + 8'(i));
    end
    repeat (2) tick();
    check_val("t3_count", if_a.TX_COUNT, 18);
    check_val("t3_busy",  if_a.BUSY, 0);
    rx_q.delete();

    // ENABLE dropped mid-frame of 0x7E
    if_a.TX_DATA = 8'h7E; if_a.TX_VALID = 1'b1;
    tick();
    if_a.TX_DATA = 8'h81;
    tick();
    if_a.TX_VALID = 1'b0;
    repeat (2) tick();
    if_a.ENABLE = 1'b0;
    if_a.TX_DATA = 8'h22; if_a.TX_VALID = 1'b1;
    tick();
    if_a.TX_VALID = 1'b0;
    wait_rx("t6_rx_first", 1, 30);
    zeros = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (if_a.TXD !== 1'b1) zeros++;
    end
    check_val("t6_line_idle", zeros, 0);
    check_val("t6_rx_n",      rx_q.size(), 1);
    if (rx_q.size() > 0) check_val("t6_rx0", rx_q[0], 8'h7E);
    check_val("t6_level",     if_a.FIFO_LEVEL, 2);
    check_val("t6_count",     if_a.TX_COUNT, 19);
    if_a.ENABLE = 1'b1;
    wait_rx("t6_rx_all", 3, 60);
    if (rx_q.size() > 2) begin
      check_val("t6_rx1", rx_q[1], 8'h81);
      check_val("t6_rx2", rx_q[2], 8'h22);
    end
    repeat (2) tick();
    check_val("t6_count_end", if_a.TX_COUNT, 21);
    rx_q.delete();

    // RESET asserted in the DATA state of 0x3C
    if_a.TX_DATA = 8'h3C; if_a.TX_VALID = 1'b1;
    tick();
    if_a.TX_DATA = 8'h99;
    tick();
    if_a.TX_VALID = 1'b0;
    repeat (2) tick();
    check_val("t4_pre_txd", if_a.TXD, 0);
    rst = 1'b1;
    #1;
    check_val("t4_txd",   if_a.TXD, 1);
    check_val("t4_level", if_a.FIFO_LEVEL, 0);
    check_val("t4_count", if_a.TX_COUNT, 0);
    check_val("t4_busy",  if_a.BUSY, 0);
    check_val("t4_ready", if_a.TX_READY, 0);
    repeat (2) tick();
    rst = 1'b0;
    #1;
    check_val("t4_ready_rel", if_a.TX_READY, 1);
    rx_q.delete();
    tick();
    if_a.TX_DATA = CHAR_EOT; if_a.TX_VALID = 1'b1;
    tick();
    if_a.TX_VALID = 1'b0;
    wait_rx("t4_rx_n", 1, 30);
    if (rx_q.size() > 0) check_val("t4_rx0", rx_q[0], 8'h04);
    repeat (2) tick();
    check_val("t4_eot",       m_eot, 1);
    check_val("t4_count_end", if_a.TX_COUNT, 1);
    check_val("t4_busy_end",  if_a.BUSY, 0);
    rx_q.delete();

`ifdef CMSDK_UART_SEND_AUX_EN
    // AUX sequence takes priority over queued "HI"
    begin
      int acks;
      acks = 0;
      if_a.ENABLE = 1'b0;
      if_a.TX_VALID = 1'b1; if_a.TX_DATA = 8'h48;
      tick();
      if_a.TX_DATA = 8'h49;
      tick();
      if_a.TX_VALID = 1'b0;
      if_a.AUX_DATA = 8'h5A; if_a.AUX_REQ = 1'b1; if_a.ENABLE = 1'b1;
      for (int t = 0; t < 80 && rx_q.size() < 5; t++) begin
        tick();
        if (if_a.AUX_ACK) begin
          acks++;
          if_a.AUX_REQ = 1'b0;
        end
      end
      check_val("t5_rx_n", rx_q.size(), 5);
      if (rx_q.size() > 4) begin
        check_val("t5_rx0", rx_q[0], 8'h1B);
        check_val("t5_rx1", rx_q[1], 8'h10);
        check_val("t5_rx2", rx_q[2], 8'h5A);
        check_val("t5_rx3", rx_q[3], 8'h48);
        check_val("t5_rx4", rx_q[4], 8'h49);
      end
      check_val("t5_auxctrl", m_aux, 8'h5A);
      check_val("t5_acks",    acks, 1);
    end
`endif

    check_val("stop_bits_ok", m_stop_err, 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
